alu_control_seq: RTL and testbench

//  Registered, handshaked successor of the combinational ALU-control decoder. Maps

---
 rtl/alu_control_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_control_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU-control decoder with multi-cycle MULT/DIV sequencing.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: undefined funcs yield NOP plus a sticky illegal flag.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// MULTI | MULT/DIV in progress, counter running, muldiv_busy=1
// OUT   | control word presented with out_valid=1 until taken
module alu_control_seq #(
  parameter int CTRL_W        = 4,
  parameter int FUNC_W        = 6,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              muldiv_busy,
  output logic              illegal
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [3:0] W_AND  = 4'b0000;
  localparam logic [3:0] W_OR   = 4'b0001;
  localparam logic [3:0] W_ADD  = 4'b0010;
  localparam logic [3:0] W_SUB  = 4'b0011;
  localparam logic [3:0] W_XOR  = 4'b0100;
  localparam logic [3:0] W_NOR  = 4'b0101;
  localparam logic [3:0] W_SLT  = 4'b0110;
  localparam logic [3:0] W_SLL  = 4'b0111;
  localparam logic [3:0] W_SRL  = 4'b1000;
  localparam logic [3:0] W_SRA  = 4'b1001;
  localparam logic [3:0] W_MULT = 4'b1010;
  localparam logic [3:0] W_DIV  = 4'b1011;
  localparam logic [3:0] W_NOP  = 4'b1111;

  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_MULTI, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [5:0]  f6;
  logic [3:0]  dec_word;
  logic        dec_illegal;
  logic        dec_muldiv;
  logic        ready_c;

  assign f6 = 6'(func);

  always_comb begin
    dec_word    = W_NOP;
    dec_illegal = 1'b0;
    dec_muldiv  = 1'b0;
    unique case (alu_op)
      2'b00: dec_word = W_ADD;
      2'b01: dec_word = W_SUB;
      2'b11: dec_word = W_OR;
      default: begin
        case (f6)
          6'b100000, 6'b100001: dec_word = W_ADD;
          6'b100010, 6'b100011: dec_word = W_SUB;
          6'b100100: dec_word = W_AND;
          6'b100101: dec_word = W_OR;
          6'b100110: dec_word = W_XOR;
          6'b100111: dec_word = W_NOR;
          6'b101010: dec_word = W_SLT;
          6'b000000: dec_word = W_SLL;
          6'b000010: dec_word = W_SRL;
          6'b000011: dec_word = W_SRA;
          6'b011000, 6'b011001: begin
            dec_word   = W_MULT;
            dec_muldiv = 1'b1;
          end
          6'b011010, 6'b011011: begin
            dec_word   = W_DIV;
            dec_muldiv = 1'b1;
          end
          default: begin
            dec_illegal = 1'b1;
            dec_word    = TRAP_EN ? W_NOP : W_ADD;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    ready_c     = 1'b0;

    case (state_q)
      S_IDLE: ready_c = 1'b1;
      S_MULTI: begin
        if (cnt_q == 8'd1) begin
          cnt_d       = 8'd0;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_OUT: begin
        ready_c = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An accept overrides the handoff-to-IDLE path so back-to-back requests have no gap.
    if (in_valid && ready_c) begin
      ctrl_d    = dec_word;
      illegal_d = TRAP_EN & dec_illegal;
      if (dec_muldiv) begin
        cnt_d       = CNT_INIT;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
        state_d     = S_MULTI;
      end else begin
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= W_NOP;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = rst_n & ready_c;
  assign out_valid   = out_valid_q;
  assign muldiv_busy = busy_q;
  assign illegal     = illegal_q;
  assign alu_control = CTRL_W'(ctrl_q);

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: table-driven reference model, random and directed traffic.
module tb_alu_control_seq;
  localparam int MC = 4;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_control;
  logic       muldiv_busy;
  logic       illegal;

  always #5 clk = ~clk;

  alu_control_seq #(.CTRL_W(4), .FUNC_W(6), .MULDIV_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .muldiv_busy(muldiv_busy), .illegal(illegal)
  );

  typedef struct {logic [3:0] w; logic ill;} exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int hand_cyc[$];
  int cyc = 0;
  int rdy_mode = 1;
  logic [3:0] rtab [logic [5:0]];
  logic [3:0] optab [int];
  logic [5:0] fcodes [18];
  logic [3:0] fwords [18];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f);
    exp_t e;
    e.ill = 1'b0;
    if (op != 2'b10) e.w = optab[int'(op)];
    else if (rtab.exists(f)) e.w = rtab[f];
    else begin
      e.w   = TRAP ? 4'hF : 4'h2;
      e.ill = TRAP;
    end
    return e;
  endfunction

  // Returns at posedge+1 of the accept edge; the expected word is queued there.
  task automatic send(input logic [1:0] op, input logic [5:0] f);
    bit acc = 0;
    alu_op = op; func = f; in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(model(op, f));
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: pops on every handoff and checks word stability while stalled.
  initial begin
    exp_t e;
    bit hold = 0;
    logic [3:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) begin
          chk("stall_word_stable", alu_control, held);
          chk("stall_valid_held", out_valid, 1);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = sb.pop_front();
            chk("alu_control", alu_control, e.w);
            chk("illegal", illegal, e.ill);
          end
          hand_cyc.push_back(cyc);
          hold = 0;
        end else if (out_valid) begin
          hold = 1; held = alu_control;
        end else hold = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, alu_control, 4'hF);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, muldiv_busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  initial begin
    exp_t e;
    fcodes = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
               6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011,
               6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b100000, 6'b100100};
    fwords = '{4'h2, 4'h2, 4'h3, 4'h3, 4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7,
               4'h8, 4'h9, 4'hA, 4'hA, 4'hB, 4'hB, 4'h2, 4'h0};
    foreach (fcodes[i]) rtab[fcodes[i]] = fwords[i];
    optab[0] = 4'h2; optab[1] = 4'h3; optab[3] = 4'h1;

    rst_n = 1'b1; in_valid = 1'b0; alu_op = 2'b00; func = '0; out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single-cycle decodes with latency 1
    rdy_mode = 1;
    for (int op = 0; op < 4; op++) begin
      if (op == 2) continue;
      send(2'(op), 6'($urandom));
      chk("lat1_valid", out_valid, 1);
    end
    foreach (fcodes[i]) begin
      send(2'b10, fcodes[i]);
      e = model(2'b10, fcodes[i]);
      if (e.w != 4'hA && e.w != 4'hB) chk("lat1_valid", out_valid, 1);
      drain(50);
    end

    // MULT timing
    send(2'b10, 6'b011000);
    for (int k = 0; k < MC; k++) begin
      @(negedge clk);
      chk("mult_busy", muldiv_busy, 1);
      chk("mult_no_valid", out_valid, 0);
      chk("mult_in_ready", in_ready, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("mult_done_valid", out_valid, 1);
    chk("mult_done_busy", muldiv_busy, 0);
    @(posedge clk); #1;
    drain(20);

    // Back-to-back SUB then AND
    hand_cyc.delete();
    send(2'b10, 6'b100010);
    send(2'b10, 6'b100100);
    drain(20);
    if (hand_cyc.size() >= 2) chk("b2b_gap", hand_cyc[1] - hand_cyc[0], 1);
    else chk("b2b_count", hand_cyc.size(), 2);

    // Stall then mid-stream reset
    rdy_mode = 2; out_ready = 1'b0;
    send(2'b11, 6'h3F);
    in_valid = 1'b1; alu_op = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ctrl", alu_control, 4'h1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0; sb.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rdy_mode = 1; out_ready = 1'b1;
    @(negedge clk);
    chk("midreset_release_ready", in_ready, 1);
    @(posedge clk); #1;

    // Undefined func, sticky illegal
    send(2'b10, 6'b111111);
    chk("illegal_accept", illegal, TRAP);
    drain(20);
    @(negedge clk);
    chk("illegal_sticky_idle", illegal, TRAP);
    @(posedge clk); #1;
    send(2'b10, 6'b100000);
    chk("illegal_cleared", illegal, 0);
    drain(20);

    // Reset during DIV at counter==2
    send(2'b10, 6'b011010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; sb.delete();
    #1 check_reset_outputs("div_abort");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (MC + 2) begin
      @(negedge clk);
      chk("div_abort_no_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(2'b10, 6'b100101);
    drain(20);

    // Random traffic
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      logic [5:0] f;
      if ($urandom_range(0, 1) == 1) f = fcodes[$urandom_range(0, 17)];
      else f = 6'($urandom);
      send(2'($urandom_range(0, 3)), f);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
